shot_clock_ctrl: RTL and testbench
==================================

SHOT_CLOCK_CTRL -- requirements
Module: shot_clock_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5_000_000: clk cycles per 0.1 s tick (50 MHz clock).
REQ-002 SHALL have parameter BUZZ_TICKS, default 10: buzzer duration in 0.1 s ticks.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that starts the countdown (debounced upstream).
REQ-006 SHALL have port stop, input, 1: single-cycle pulse that pauses the countdown.
REQ-007 SHALL have port reset_24, input, 1: single-cycle pulse that reloads 24.0 s.
REQ-008 SHALL have port reset_14, input, 1: single-cycle pulse that conditionally reloads 14.0 s.
REQ-009 SHALL have port hex1, output, 7: active-low segments for the left digit.
REQ-010 SHALL have port hex0, output, 7: active-low segments for the right digit.
REQ-011 SHALL have port dp_n, output, 1: active-low decimal point between the digits.
REQ-012 SHALL have port buzzer, output, 1: high while the expiry horn sounds.
REQ-013 SHALL have ports running and expired, output, 1 each: high in RUN and EXPIRED respectively.

Function
REQ-014 SHALL hold count, 8-bit unsigned, in tenths of a second, range 0..240.
REQ-015 SHALL implement states PAUSE, RUN and EXPIRED.
REQ-016 SHALL resolve simultaneous pulses in priority order reset_24 > reset_14 > stop > start; only the highest-priority pulse acts.
REQ-017 reset_24 SHALL, from any state, load count=240, clear the prescaler and buzzer, and enter PAUSE.
REQ-018 reset_14 SHALL load count=140, clear the prescaler and buzzer, and enter PAUSE only when count<140 or the state is EXPIRED; otherwise it SHALL have no effect.
REQ-019 start SHALL move PAUSE->RUN when count>0; it SHALL be ignored in RUN, in EXPIRED, or when count==0.
REQ-020 stop SHALL move RUN->PAUSE, holding both the prescaler and count; it SHALL be ignored in other states.
REQ-021 The prescaler SHALL count 0..TICK_DIV-1 in RUN and EXPIRED (while the buzzer is on), and SHALL emit a one-cycle tick at TICK_DIV-1 before wrapping to 0.
REQ-022 A tick in RUN SHALL decrement count by 1. When count goes 1->0, the block SHALL enter EXPIRED and raise buzzer on the next cycle.
REQ-023 buzzer SHALL stay high for exactly BUZZ_TICKS ticks, then clear. The block SHALL remain in EXPIRED with count=0 until reset_24, reset_14 or reset.
REQ-024 Display for count>=50 SHALL show value=ceil(count/10): hex1=tens digit, blanked (7'h7F) when 0; hex0=ones digit; dp_n=1.
REQ-025 Display for count<50 SHALL show hex1=count/10, hex0=count%10 (no blanking), dp_n=0, i.e. "4.9" down to "0.0".
REQ-026 Digit to segment encoding SHALL be standard active-low hex (0=7'b1000000, 8=7'b0000000).
REQ-027 All outputs SHALL be registered; a display change SHALL appear one cycle after the count changes.

Reset
REQ-028 reset SHALL set count=240, prescaler=0, buzzer counter=0 and state=PAUSE. Outputs SHALL then be hex1="2", hex0="4", dp_n=1, buzzer=0, running=0, expired=0.
REQ-029 reset asserted mid-RUN or mid-buzzer SHALL override all pulses in that cycle.

Structure
REQ-030 Package shot_clock_pkg SHALL hold the state enum plus the constants FULL_TENTHS=240, SHORT_TENTHS=140, TENTHS_THRESH=50 and SEG_BLANK=7'h7F.
REQ-031 Segment encoding SHALL reuse the existing dec_to_disp module, two instances, with registered outputs. Blanking SHALL be a mux after the hex1 decoder.

Verification (TICK_DIV=4, BUZZ_TICKS=3)
REQ-032 Reset then start, run 40 cycles: count=230, display "23", dp_n=1, running=1.
REQ-033 Run from 240 down to 49: at count 50 display "5"; next tick display "4.9" with dp_n=0.
REQ-034 Run to 0: expired=1, buzzer high exactly 12 cycles, then buzzer=0 and display "0.0" held. start ignored. reset_14 -> "14" in PAUSE.
REQ-035 At count=180, pulse reset_14: count stays 180. At count=90, pulse reset_14: count=140, PAUSE.
REQ-036 stop at prescaler=2, then start 10 cycles later: next decrement occurs 2 cycles after resume.
REQ-037 start and reset_24 in the same cycle during RUN at count=100: count=240, state PAUSE, running=0.

Source files
------------

// File: rtl/shot_clock_pkg.sv
// Shared types and constants for the basketball shot clock controller.
package shot_clock_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE   = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam int unsigned COUNT_W = 8;

    localparam logic [COUNT_W-1:0] FULL_TENTHS   = 8'd240;
    localparam logic [COUNT_W-1:0] SHORT_TENTHS  = 8'd140;
    localparam logic [COUNT_W-1:0] TENTHS_THRESH = 8'd50;
    localparam logic [6:0]         SEG_BLANK     = 7'h7F;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       blank;
        logic       dp_n;
    } disp_t;

    // Whole seconds rounded up at 5 s and above, tenths below.
    function automatic disp_t count_to_disp(input logic [COUNT_W-1:0] count);
        disp_t              d;
        logic [COUNT_W-1:0] secs;
        secs = '0;
        if (count >= TENTHS_THRESH) begin
            secs    = (count + 8'd9) / 8'd10;
            d.tens  = 4'(secs / 8'd10);
            d.ones  = 4'(secs % 8'd10);
            d.blank = (secs < 8'd10);
            d.dp_n  = 1'b1;
        end else begin
            d.tens  = 4'(count / 8'd10);
            d.ones  = 4'(count % 8'd10);
            d.blank = 1'b0;
            d.dp_n  = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/dec_to_disp.sv
// Hex digit to active-low seven-segment pattern (gfedcba).
module dec_to_disp (
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = 7'h7F;
        case (digit)
            4'h0: seg_c = 7'b1000000;
            4'h1: seg_c = 7'b1111001;
            4'h2: seg_c = 7'b0100100;
            4'h3: seg_c = 7'b0110000;
            4'h4: seg_c = 7'b0011001;
            4'h5: seg_c = 7'b0010010;
            4'h6: seg_c = 7'b0000010;
            4'h7: seg_c = 7'b1111000;
            4'h8: seg_c = 7'b0000000;
            4'h9: seg_c = 7'b0010000;
            4'hA: seg_c = 7'b0001000;
            4'hB: seg_c = 7'b0000011;
            4'hC: seg_c = 7'b1000110;
            4'hD: seg_c = 7'b0100001;
            4'hE: seg_c = 7'b0000110;
            4'hF: seg_c = 7'b0001110;
            default: seg_c = 7'h7F;
        endcase
    end

endmodule

// File: rtl/shot_clock_ctrl.sv
// 24-second shot clock: tenth-second countdown, expiry horn and two-digit display.
module shot_clock_ctrl
    import shot_clock_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 5_000_000,
    parameter int unsigned BUZZ_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       reset_24,
    input  logic       reset_14,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       dp_n,
    output logic       buzzer,
    output logic       running,
    output logic       expired
);

    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BUZZ_W = (BUZZ_TICKS > 1) ? $clog2(BUZZ_TICKS + 1) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_TICKS - 1);
    localparam logic [6:0]        RST_HEX1  = 7'b0100100;
    localparam logic [6:0]        RST_HEX0  = 7'b0011001;

    state_t              state, state_nxt;
    logic [COUNT_W-1:0]  count, count_nxt;
    logic [PRE_W-1:0]    pre, pre_nxt;
    logic [BUZZ_W-1:0]   buzz_cnt, buzz_cnt_nxt;
    logic                buzz_on, buzz_on_nxt;

    logic                load;
    logic                stop_act;
    logic                start_act;
    logic                prescale_en;
    logic                tick;
    logic [COUNT_W-1:0]  load_val;

    // Pulse arbitration: the highest-priority asserted pulse claims the cycle.
    assign load        = reset_24 ||
                         (reset_14 && ((count < SHORT_TENTHS) || (state == ST_EXPIRED)));
    assign load_val    = reset_24 ? FULL_TENTHS : SHORT_TENTHS;
    assign stop_act    = !reset_24 && !reset_14 && stop && (state == ST_RUN);
    assign start_act   = !reset_24 && !reset_14 && !stop && start &&
                         (state == ST_PAUSE) && (count != 8'd0);
    assign prescale_en = (state == ST_RUN) || ((state == ST_EXPIRED) && buzz_on);
    assign tick        = prescale_en && (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_PAUSE;
            count    <= FULL_TENTHS;
            pre      <= '0;
            buzz_cnt <= '0;
            buzz_on  <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            pre      <= pre_nxt;
            buzz_cnt <= buzz_cnt_nxt;
            buzz_on  <= buzz_on_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        pre_nxt      = pre;
        buzz_cnt_nxt = buzz_cnt;
        buzz_on_nxt  = buzz_on;
        if (load) begin
            state_nxt    = ST_PAUSE;
            count_nxt    = load_val;
            pre_nxt      = '0;
            buzz_cnt_nxt = '0;
            buzz_on_nxt  = 1'b0;
        end else if (stop_act) begin
            // Prescaler is frozen so the partial tenth resumes where it left off.
            state_nxt = ST_PAUSE;
        end else begin
            if (start_act) begin
                state_nxt = ST_RUN;
            end
            if (tick) begin
                pre_nxt = '0;
                if (state == ST_RUN) begin
                    count_nxt = count - 8'd1;
                    if (count == 8'd1) begin
                        state_nxt    = ST_EXPIRED;
                        buzz_on_nxt  = 1'b1;
                        buzz_cnt_nxt = '0;
                    end
                end else if (buzz_cnt == BUZZ_LAST) begin
                    buzz_on_nxt  = 1'b0;
                    buzz_cnt_nxt = '0;
                end else begin
                    buzz_cnt_nxt = buzz_cnt + BUZZ_W'(1);
                end
            end else if (prescale_en) begin
                pre_nxt = pre + PRE_W'(1);
            end
        end
    end

    disp_t      disp;
    logic [6:0] seg1;
    logic [6:0] seg0;

    assign disp = count_to_disp(count);

    dec_to_disp u_dec_hex1 (
        .digit (disp.tens),
        .seg_c (seg1)
    );

    dec_to_disp u_dec_hex0 (
        .digit (disp.ones),
        .seg_c (seg0)
    );

    // Output stage lags internal state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex1    <= RST_HEX1;
            hex0    <= RST_HEX0;
            dp_n    <= 1'b1;
            buzzer  <= 1'b0;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            hex1    <= disp.blank ? SEG_BLANK : seg1;
            hex0    <= seg0;
            dp_n    <= disp.dp_n;
            buzzer  <= buzz_on;
            running <= (state == ST_RUN);
            expired <= (state == ST_EXPIRED);
        end
    end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Scoreboard bench for shot_clock_ctrl with a 4-cycle tick and 3-tick horn.
module tb_shot_clock_ctrl;

    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12;
    localparam logic [6:0] S6 = 7'h02;
    localparam logic [6:0] S7 = 7'h78;
    localparam logic [6:0] S8 = 7'h00;
    localparam logic [6:0] S9 = 7'h10;
    localparam logic [6:0] SB = 7'h7F;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       reset_24;
    logic       reset_14;
    logic [6:0] hex1;
    logic [6:0] hex0;
    logic       dp_n;
    logic       buzzer;
    logic       running;
    logic       expired;

    shot_clock_ctrl #(
        .TICK_DIV   (4),
        .BUZZ_TICKS (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .reset_24 (reset_24),
        .reset_14 (reset_14),
        .hex1     (hex1),
        .hex0     (hex0),
        .dp_n     (dp_n),
        .buzzer   (buzzer),
        .running  (running),
        .expired  (expired)
    );

    typedef struct {
        string       name;
        bit          is_len;
        logic [17:0] outs;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   run_len  = 0;
    int   buzz_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Length of the most recent completed buzzer burst, in cycles.
    always @(negedge clk) begin
        if (buzzer === 1'b1) begin
            run_len = run_len + 1;
        end else if (run_len != 0) begin
            buzz_len = run_len;
            run_len  = 0;
        end
    end

    // Monitor: pops one expectation per falling edge and compares it.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if (e.is_len) begin
                if (buzz_len !== e.len) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: got %0d cycles, required %0d", e.name, buzz_len, e.len);
                end
            end else if ({hex1, hex0, dp_n, buzzer, running, expired} !== e.outs) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got hex1=%h hex0=%h dp_n=%b buz=%b run=%b exp=%b, required hex1=%h hex0=%h dp_n=%b buz=%b run=%b exp=%b",
                         e.name, hex1, hex0, dp_n, buzzer, running, expired,
                         e.outs[17:11], e.outs[10:4], e.outs[3], e.outs[2], e.outs[1], e.outs[0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [6:0] h1, input logic [6:0] h0,
                              input logic dp, input logic bz, input logic rn, input logic ex);
        exp_t x;
        x.name   = name;
        x.is_len = 1'b0;
        x.outs   = {h1, h0, dp, bz, rn, ex};
        x.len    = 0;
        exp_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_len(input string name, input int len);
        exp_t x;
        x.name   = name;
        x.is_len = 1'b1;
        x.outs   = '0;
        x.len    = len;
        exp_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: start    = 1'b1;
            1: stop     = 1'b1;
            2: reset_24 = 1'b1;
            default: reset_14 = 1'b1;
        endcase
        step(1);
        start    = 1'b0;
        stop     = 1'b0;
        reset_24 = 1'b0;
        reset_14 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        reset_24 = 1'b0;
        reset_14 = 1'b0;
        step(3);
        reset = 1'b0;
        expect_out("reset_state", S2, S4, 1'b1, 1'b0, 1'b0, 1'b0);

        // Full run from 24.0 down to expiry; start edge is E.
        pulse(0);
        step(41);
        expect_out("run_230_shows_23", S2, S3, 1'b1, 1'b0, 1'b1, 1'b0);
        step(719);
        expect_out("count_51_shows_6", SB, S6, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1);
        expect_out("count_50_shows_5", SB, S5, 1'b1, 1'b0, 1'b1, 1'b0);
        step(4);
        expect_out("count_49_shows_4.9", S4, S9, 1'b0, 1'b0, 1'b1, 1'b0);
        step(192);
        expect_out("count_1_shows_0.1", S0, S1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4);
        expect_out("expired_buzzer_on", S0, S0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(11);
        expect_out("buzzer_last_cycle", S0, S0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        expect_out("buzzer_cleared", S0, S0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(2);
        expect_len("buzzer_length", 12);
        pulse(0);
        step(1);
        expect_out("start_ignored_expired", S0, S0, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse(3);
        step(1);
        expect_out("reset14_from_expired", S1, S4, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset_14 above 14.0 is ignored; stop at prescaler phase 2.
        pulse(2);
        step(1);
        expect_out("reset24_reload", S2, S4, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(0);
        step(240);
        pulse(3);
        step(1);
        expect_out("reset14_ignored_at_180", S1, S8, 1'b1, 1'b0, 1'b1, 1'b0);
        pulse(1);
        step(1);
        expect_out("stop_holds_180", S1, S8, 1'b1, 1'b0, 1'b0, 1'b0);
        step(9);
        pulse(0);
        step(38);
        expect_out("resume_phase_171", S1, S8, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1);
        expect_out("resume_phase_170", S1, S7, 1'b1, 1'b0, 1'b1, 1'b0);
        step(319);
        pulse(3);
        step(1);
        expect_out("reset14_at_90", S1, S4, 1'b1, 1'b0, 1'b0, 1'b0);

        // start and reset_24 together at count 100.
        pulse(0);
        step(161);
        expect_out("count_100_shows_10", S1, S0, 1'b1, 1'b0, 1'b1, 1'b0);
        start    = 1'b1;
        reset_24 = 1'b1;
        step(1);
        start    = 1'b0;
        reset_24 = 1'b0;
        step(1);
        expect_out("reset24_beats_start", S2, S4, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8);
        expect_out("reset24_stays_paused", S2, S4, 1'b1, 1'b0, 1'b0, 1'b0);

        // Synchronous reset overrides a simultaneous start mid-run.
        pulse(0);
        step(10);
        reset = 1'b1;
        start = 1'b1;
        step(1);
        reset = 1'b0;
        start = 1'b0;
        step(1);
        expect_out("reset_mid_run", S2, S4, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5);
        expect_out("reset_overrides_start", S2, S4, 1'b1, 1'b0, 1'b0, 1'b0);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
